// File: rtl/jalr_pred_check_pkg.sv
// Shared constants and types for the jalr target-prediction checker.
package jalr_pred_check_pkg;

    // All-zero machine word, used as the reset value of redirect_pc.
    localparam logic [31:0] ZEROWORD = 32'h0000_0000;

    // Default widths for the checker's parameters.
    localparam int DEF_QUEUE_ADDR_WIDTH = 2;
    localparam int DEF_CNT_WIDTH        = 16;

    // Outcome of a resolving jalr in a given cycle.
    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_HIT  = 2'd1,
        RES_MISS = 2'd2
    } res_kind_e;

endpackage

// File: rtl/jalr_pred_check_pred_fifo.sv
// In-order queue of predicted jalr targets. Head is read combinationally
// so the resolve compare can happen in the same cycle.
module jalr_pred_check_pred_fifo #(
    parameter int QUEUE_ADDR_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty
);

    localparam int DEPTH = 1 << QUEUE_ADDR_WIDTH;
    localparam int CW    = QUEUE_ADDR_WIDTH + 1;

    // Storage is not reset; only the pointers and occupancy define validity.
    logic [31:0]                 mem_reg [DEPTH];
    logic [QUEUE_ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [QUEUE_ADDR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]               count_reg, count_next;
    logic                        do_push;
    logic                        do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign dout  = mem_reg[rd_ptr_reg];

    // Qualify requests: a push into a full queue is only legal alongside a pop.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Next pointer/occupancy; a clear wins over everything else.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (clear) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = wr_ptr_reg + QUEUE_ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + QUEUE_ADDR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage write at the write pointer; suppressed when the queue is cleared.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

endmodule

// File: rtl/jalr_pred_check.sv
// Checks resolved jalr targets against the oldest front-end prediction,
// raises a one-cycle redirect on a miss and keeps hit/miss counters.
module jalr_pred_check
    import jalr_pred_check_pkg::*;
#(
    parameter int QUEUE_ADDR_WIDTH = DEF_QUEUE_ADDR_WIDTH,
    parameter int CNT_WIDTH        = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pred_valid,
    input  logic [31:0]          pred_target,
    input  logic                 resolve_valid,
    input  logic [31:0]          resolve_target,
    input  logic                 ext_flush,
    output logic                 queue_full,
    output logic                 queue_empty,
    output logic                 mispredict,
    output logic [31:0]          redirect_pc,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [31:0]          fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_clear;
    logic                 push_req;
    logic                 push_drop;
    res_kind_e            res_kind;

    logic                 mispredict_reg, mispredict_next;
    logic [31:0]          redirect_pc_reg, redirect_pc_next;
    logic                 overflow_reg, overflow_next;
    logic [1:0]           cnt_inc;
    logic [CNT_WIDTH-1:0] cnt_val [2];

    jalr_pred_check_pred_fifo #(
        .QUEUE_ADDR_WIDTH(QUEUE_ADDR_WIDTH)
    ) u_pred_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (fifo_push),
        .pop  (fifo_pop),
        .clear(fifo_clear),
        .din  (pred_target),
        .dout (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Classify the resolving jalr; an external flush masks it entirely.
    // An empty queue means no prediction exists, which counts as a miss.
    always_comb begin
        res_kind = RES_NONE;
        if (!ext_flush && resolve_valid) begin
            if (!fifo_empty && (fifo_head == resolve_target)) begin
                res_kind = RES_HIT;
            end else begin
                res_kind = RES_MISS;
            end
        end
    end

    // Queue control: flush or miss empties it and blocks a same-cycle enqueue;
    // a full queue only accepts a new prediction when a hit frees the head.
    always_comb begin
        fifo_clear = ext_flush || (res_kind == RES_MISS);
        fifo_pop   = (res_kind == RES_HIT);
        push_req   = pred_valid && !fifo_clear;
        fifo_push  = push_req && (!fifo_full || fifo_pop);
        push_drop  = push_req && fifo_full && !fifo_pop;
    end

    // Next-state for the redirect pulse and the sticky overflow flag.
    always_comb begin
        mispredict_next  = (res_kind == RES_MISS);
        redirect_pc_next = redirect_pc_reg;
        overflow_next    = overflow_reg || push_drop;
        if (res_kind == RES_MISS) begin
            redirect_pc_next = resolve_target;
        end
    end

    // Redirect pulse, redirect target and overflow registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mispredict_reg  <= 1'b0;
            redirect_pc_reg <= ZEROWORD;
            overflow_reg    <= 1'b0;
        end else begin
            mispredict_reg  <= mispredict_next;
            redirect_pc_reg <= redirect_pc_next;
            overflow_reg    <= overflow_next;
        end
    end

    // Counter 0 tracks hits, counter 1 tracks misses.
    assign cnt_inc = {(res_kind == RES_MISS), (res_kind == RES_HIT)};

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
        logic [CNT_WIDTH-1:0] cnt_reg;

        // Saturating performance counter.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (cnt_inc[gi]) begin
                cnt_reg <= sat_inc(cnt_reg);
            end
        end

        assign cnt_val[gi] = cnt_reg;
    end

    assign queue_full  = fifo_full;
    assign queue_empty = fifo_empty;
    assign mispredict  = mispredict_reg;
    assign redirect_pc = redirect_pc_reg;
    assign overflow    = overflow_reg;
    assign hit_count   = cnt_val[0];
    assign miss_count  = cnt_val[1];

endmodule

// File: tb/tb_jalr_pred_check.sv
// Directed, table-driven bench for jalr_pred_check (4-bit counters).
module tb_jalr_pred_check;

    localparam int QAW = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pred_valid;
    logic [31:0]   pred_target;
    logic          resolve_valid;
    logic [31:0]   resolve_target;
    logic          ext_flush;
    logic          queue_full;
    logic          queue_empty;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic          overflow;
    logic [CW-1:0] hit_count;
    logic [CW-1:0] miss_count;

    int checks   = 0;
    int failures = 0;

    jalr_pred_check #(
        .QUEUE_ADDR_WIDTH(QAW),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_valid    (pred_valid),
        .pred_target   (pred_target),
        .resolve_valid (resolve_valid),
        .resolve_target(resolve_target),
        .ext_flush     (ext_flush),
        .queue_full    (queue_full),
        .queue_empty   (queue_empty),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .overflow      (overflow),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        pv;
        logic [31:0] pt;
        logic        rv;
        logic [31:0] rt;
        logic        fl;
        logic        e_empty;
        logic        e_full;
        logic        e_mp;
        logic [31:0] e_rpc;
        logic        e_ovf;
        int          e_hit;
        int          e_miss;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic pv, input logic [31:0] pt,
                                input logic rv, input logic [31:0] rt, input logic fl,
                                input logic ee, input logic ef, input logic emp,
                                input logic [31:0] erpc, input logic eov,
                                input int eh, input int em);
        vec_t v;
        v.rst_n = r;  v.pv = pv; v.pt = pt; v.rv = rv; v.rt = rt; v.fl = fl;
        v.e_empty = ee; v.e_full = ef; v.e_mp = emp; v.e_rpc = erpc;
        v.e_ovf = eov; v.e_hit = eh; v.e_miss = em;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic pv, input logic [31:0] pt,
                         input logic rv, input logic [31:0] rt, input logic fl);
        rst_n          = r;
        pred_valid     = pv;
        pred_target    = pt;
        resolve_valid  = rv;
        resolve_target = rt;
        ext_flush      = fl;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [27];

    initial begin
        rst_n = 1'b0; pred_valid = 1'b0; pred_target = '0;
        resolve_valid = 1'b0; resolve_target = '0; ext_flush = 1'b0;

        //              rst pv pt            rv rt            fl  emp ful mp rpc           ovf hit miss
        vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,        0,  1, 0, 0, 32'h0,        0, 0, 0);
        // hit path
        vecs[1]  = mk(1, 1, 32'h0000_1004, 0, 32'h0,       0,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[2]  = mk(1, 1, 32'h0000_2008, 0, 32'h0,       0,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[3]  = mk(1, 0, 32'h0,        1, 32'h0000_1004, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[4]  = mk(1, 0, 32'h0,        1, 32'h0000_2008, 0, 1, 0, 0, 32'h0,        0, 2, 0);
        // miss flush with same-cycle enqueue dropped
        vecs[5]  = mk(1, 1, 32'h100,      0, 32'h0,        0,  0, 0, 0, 32'h0,        0, 2, 0);
        vecs[6]  = mk(1, 1, 32'h200,      0, 32'h0,        0,  0, 0, 0, 32'h0,        0, 2, 0);
        vecs[7]  = mk(1, 1, 32'h300,      0, 32'h0,        0,  0, 0, 0, 32'h0,        0, 2, 0);
        vecs[8]  = mk(1, 1, 32'h400,      1, 32'h104,      0,  1, 0, 1, 32'h104,      0, 2, 1);
        vecs[9]  = mk(1, 0, 32'h0,        0, 32'h0,        0,  1, 0, 0, 32'h104,      0, 2, 1);
        // fill, overflow, hit+enqueue while full, drain across wrap
        vecs[10] = mk(1, 1, 32'hA0,       0, 32'h0,        0,  0, 0, 0, 32'h104,      0, 2, 1);
        vecs[11] = mk(1, 1, 32'hA1,       0, 32'h0,        0,  0, 0, 0, 32'h104,      0, 2, 1);
        vecs[12] = mk(1, 1, 32'hA2,       0, 32'h0,        0,  0, 0, 0, 32'h104,      0, 2, 1);
        vecs[13] = mk(1, 1, 32'hA3,       0, 32'h0,        0,  0, 1, 0, 32'h104,      0, 2, 1);
        vecs[14] = mk(1, 1, 32'hA4,       0, 32'h0,        0,  0, 1, 0, 32'h104,      1, 2, 1);
        vecs[15] = mk(1, 1, 32'h500,      1, 32'hA0,       0,  0, 1, 0, 32'h104,      1, 3, 1);
        vecs[16] = mk(1, 0, 32'h0,        1, 32'hA1,       0,  0, 0, 0, 32'h104,      1, 4, 1);
        vecs[17] = mk(1, 0, 32'h0,        1, 32'hA2,       0,  0, 0, 0, 32'h104,      1, 5, 1);
        vecs[18] = mk(1, 0, 32'h0,        1, 32'hA3,       0,  0, 0, 0, 32'h104,      1, 6, 1);
        vecs[19] = mk(1, 0, 32'h0,        1, 32'h500,      0,  1, 0, 0, 32'h104,      1, 7, 1);
        // empty-queue resolve is a miss
        vecs[20] = mk(1, 0, 32'h0,        1, 32'h80,       0,  1, 0, 1, 32'h80,       1, 7, 2);
        vecs[21] = mk(1, 1, 32'h10,       0, 32'h0,        0,  0, 0, 0, 32'h80,       1, 7, 2);
        // flush beats resolve and enqueue
        vecs[22] = mk(1, 1, 32'h20,       1, 32'h10,       1,  1, 0, 0, 32'h80,       1, 7, 2);
        // back-to-back misses give back-to-back pulses
        vecs[23] = mk(1, 0, 32'h0,        1, 32'h11,       0,  1, 0, 1, 32'h11,       1, 7, 3);
        vecs[24] = mk(1, 0, 32'h0,        1, 32'h12,       0,  1, 0, 1, 32'h12,       1, 7, 4);
        vecs[25] = mk(1, 0, 32'h0,        0, 32'h0,        0,  1, 0, 0, 32'h12,       1, 7, 4);
        // reset clears everything again
        vecs[26] = mk(0, 1, 32'h33,       1, 32'h44,       0,  1, 0, 0, 32'h0,        0, 0, 0);

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].rst_n, vecs[i].pv, vecs[i].pt, vecs[i].rv, vecs[i].rt, vecs[i].fl);
            check("queue_empty", i, 32'(queue_empty), 32'(vecs[i].e_empty));
            check("queue_full",  i, 32'(queue_full),  32'(vecs[i].e_full));
            check("mispredict",  i, 32'(mispredict),  32'(vecs[i].e_mp));
            check("redirect_pc", i, redirect_pc,      vecs[i].e_rpc);
            check("overflow",    i, 32'(overflow),    32'(vecs[i].e_ovf));
            check("hit_count",   i, 32'(hit_count),   32'(vecs[i].e_hit));
            check("miss_count",  i, 32'(miss_count),  32'(vecs[i].e_miss));
            $display("vec %0d: empty=%0d full=%0d mp=%0d rpc=%h ovf=%0d hit=%0d miss=%0d",
                     i, queue_empty, queue_full, mispredict, redirect_pc, overflow,
                     hit_count, miss_count);
        end

        // Saturation: 17 hits on a 4-bit counter must stick at 0xF.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 32'h1000 + 32'(i), 1'b0, 32'h0, 1'b0);
            drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i), 1'b0);
            check("sat_hit", 100 + i, 32'(hit_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            $display("sat %0d: hit=%0d miss=%0d mp=%0d", i, hit_count, miss_count, mispredict);
        end
        check("sat_miss",  200, 32'(miss_count),  32'd0);
        check("sat_empty", 201, 32'(queue_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
